// File: rtl/clint_bridge_if.sv
// CPU request/response and CLINT register-port signals shared by the bridge and its requester.
interface clint_bridge_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic        i_req_we;
    logic [31:0] i_req_wdata;
    logic [3:0]  i_req_be;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [15:0] o_offset;
    logic        o_we;
    logic [31:0] o_wdata;
    logic [31:0] i_rdata;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_we, i_req_wdata, i_req_be, i_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_offset, o_we, o_wdata
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_we, i_req_wdata, i_req_be, i_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_offset, o_we, o_wdata
    );
endinterface

// File: rtl/clint_bridge.sv
// Bridges a CPU valid/ready request onto a word-addressed CLINT register port.
// 2-5 cycles accept-to-response, one request in flight; the response pulse has no backpressure.
module clint_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h6000_0000,
    parameter logic [31:0] SPAN      = 32'h0001_0000
) (
    input  logic          CLK,
    input  logic          RST,
    clint_bridge_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAP, WR, RESP} state_t;
    state_t state, state_nxt;

    logic        accept;
    logic        in_win;
    logic        req_bad;
    logic [32:0] addr_ext;
    logic [32:0] win_lo;
    logic [32:0] win_hi;
    logic [15:0] offset_nxt;
    logic        we_q;
    logic        err_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;

    // 33-bit compare so a window ending at 2^32 does not wrap onto address 0
    assign addr_ext   = {1'b0, bus.i_req_addr};
    assign win_lo     = {1'b0, BASE_ADDR};
    assign win_hi     = win_lo + {1'b0, SPAN};
    assign in_win     = (addr_ext >= win_lo) && (addr_ext < win_hi);
    assign req_bad    = !in_win || (bus.i_req_addr[1:0] != 2'b00);
    assign offset_nxt = bus.i_req_addr[15:0] - BASE_ADDR[15:0];
    assign accept     = bus.i_req_valid && (state == IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        bus.o_req_ready = 1'b0;
        bus.o_we        = 1'b0;
        bus.o_rsp_valid = 1'b0;
        bus.o_rsp_rdata = '0;
        bus.o_rsp_err   = 1'b0;
        case (state)
            IDLE: begin
                bus.o_req_ready = 1'b1;
                if (accept) begin
                    if (req_bad)                       state_nxt = RESP;
                    else if (!bus.i_req_we)            state_nxt = RD_ISSUE;
                    else if (bus.i_req_be == 4'b0000)  state_nxt = RESP;
                    else if (bus.i_req_be == 4'b1111)  state_nxt = WR;
                    else                               state_nxt = RD_ISSUE;
                end
            end
            RD_ISSUE: state_nxt = RD_CAP;
            RD_CAP:   state_nxt = we_q ? WR : RESP;
            WR: begin
                bus.o_we  = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                bus.o_rsp_valid = 1'b1;
                bus.o_rsp_rdata = rdata_q;
                bus.o_rsp_err   = err_q;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.o_offset <= '0;
            bus.o_wdata  <= '0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            be_q         <= '0;
            rdata_q      <= '0;
        end else if (accept) begin
            bus.o_offset <= offset_nxt;
            we_q         <= bus.i_req_we;
            be_q         <= bus.i_req_be;
            err_q        <= req_bad;
            rdata_q      <= '0;
            if (bus.i_req_we && !req_bad) bus.o_wdata <= bus.i_req_wdata;
        end else if (state == RD_CAP) begin
            // partial write: unenabled bytes come from the current register value
            if (we_q) begin
                for (int k = 0; k < 4; k++) begin
                    if (!be_q[k]) bus.o_wdata[8*k +: 8] <= bus.i_rdata[8*k +: 8];
                end
            end else begin
                rdata_q <= bus.i_rdata;
            end
        end
    end
endmodule
